// File: rtl/uart_rx_buffer_pkg.sv
// Shared types and constants for the UART receive line buffer.
package uart_pkg;

  typedef logic [7:0] uart_byte_t;

  typedef enum logic {
    RXB_WAIT,
    RXB_DRAIN
  } rxb_state_t;

  localparam uart_byte_t UART_EOL = 8'h0A;

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Byte-in / line-out stream bundle between uart_rx, the line buffer and its consumer.
interface uart_rx_buffer_if
  import uart_pkg::*;
#(
  parameter int depth_log2 = 4
);

  uart_byte_t            i_data;
  logic                  i_valid;
  logic                  i_clear;
  logic                  i_ready;
  uart_byte_t            o_data;
  logic                  o_valid;
  logic [depth_log2:0]   o_count;
  logic [depth_log2:0]   o_lines;
  logic                  o_overflow;
  logic [31:0]           o_sum;

  modport master (
    output i_data, i_valid, i_clear, i_ready,
    input  o_data, o_valid, o_count, o_lines, o_overflow, o_sum
  );

  modport slave (
    input  i_data, i_valid, i_clear, i_ready,
    output o_data, o_valid, o_count, o_lines, o_overflow, o_sum
  );

endinterface

// File: rtl/uart_rx_buffer_fifo.sv
// First-word fall-through byte FIFO; clear takes priority over push and pop.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int depth_log2 = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                push,
  input  logic                pop,
  input  uart_byte_t          wr_data,
  output uart_byte_t          rd_data,
  output logic [depth_log2:0] count,
  output logic                full,
  output logic                empty
);

  localparam int DEPTH = 2 ** depth_log2;

  uart_byte_t              mem [DEPTH];
  logic [depth_log2-1:0]   wr_ptr_reg;
  logic [depth_log2-1:0]   rd_ptr_reg;
  logic [depth_log2:0]     count_reg;

  // Storage carries no reset: contents are only meaningful below count_reg.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;
  assign full    = (count_reg == (depth_log2 + 1)'(DEPTH));
  assign empty   = (count_reg == '0);

endmodule

// File: rtl/uart_rx_buffer.sv
// Line-assembling receive buffer: releases bytes one whole line at a time.
// Optional running byte sum enabled by defining UART_RX_BUFFER_SUM_EN.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int         depth_log2 = 4,
  parameter uart_byte_t eol_char   = UART_EOL
) (
  input logic              clk,
  input logic              rst_n,
  uart_rx_buffer_if.slave  bus
);

  localparam int DEPTH = 2 ** depth_log2;

  rxb_state_t            state_reg, state_next;
  logic [depth_log2:0]   lines_reg, lines_next;
  logic [depth_log2:0]   count, count_after;
  logic                  overflow_reg;
  logic                  full, empty, push, pop, drop, valid;
  logic                  push_eol, pop_eol;
  uart_byte_t            head;

  uart_fifo #(.depth_log2(depth_log2)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (bus.i_clear),
    .push    (push),
    .pop     (pop),
    .wr_data (bus.i_data),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // A full FIFO may still accept a byte when the consumer frees a slot this cycle.
  assign pop      = valid && bus.i_ready;
  assign push     = bus.i_valid && (!full || pop);
  assign drop     = bus.i_valid && full && !pop;
  assign push_eol = push && (bus.i_data == eol_char);
  assign pop_eol  = pop && (head == eol_char);

  assign count_after = count + {{depth_log2{1'b0}}, push} - {{depth_log2{1'b0}}, pop};

  always_comb begin
    lines_next = lines_reg;
    if (push_eol && !pop_eol)      lines_next = lines_reg + 1'b1;
    else if (pop_eol && !push_eol) lines_next = lines_reg - 1'b1;
  end

  // Decisions look at post-edge occupancy so a completed line is offered the very next cycle.
  always_comb begin
    state_next = state_reg;
    valid      = 1'b0;
    unique case (state_reg)
      RXB_WAIT: begin
        if (lines_next != '0 || count_after == (depth_log2 + 1)'(DEPTH))
          state_next = RXB_DRAIN;
      end
      RXB_DRAIN: begin
        valid = !empty;
        if (pop_eol || (lines_next == '0 && count_after == '0))
          state_next = RXB_WAIT;
      end
      default: state_next = RXB_WAIT;
    endcase
    if (bus.i_clear) state_next = RXB_WAIT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= RXB_WAIT;
      lines_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (bus.i_clear) begin
      state_reg    <= RXB_WAIT;
      lines_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      lines_reg <= lines_next;
      if (drop) overflow_reg <= 1'b1;
    end
  end

`ifdef UART_RX_BUFFER_SUM_EN
  logic [31:0] sum_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           sum_reg <= '0;
    else if (bus.i_clear) sum_reg <= '0;
    else if (push)        sum_reg <= sum_reg + {24'd0, bus.i_data};
  end

  assign bus.o_sum = sum_reg;
`else
  assign bus.o_sum = 32'd0;
`endif

  assign bus.o_data     = head;
  assign bus.o_valid    = valid;
  assign bus.o_count    = count;
  assign bus.o_lines    = lines_reg;
  assign bus.o_overflow = overflow_reg;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed vector bench for uart_rx_buffer: per-cycle table plus a sum/async-reset sequence.
module tb_uart_rx_buffer;

  logic clk;
  logic rst_n;

  uart_rx_buffer_if #(.depth_log2(4)) bus ();

  uart_rx_buffer #(.depth_log2(4), .eol_char(8'h0A)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       clear;
    logic       e_valid;
    logic [7:0] e_data;
    logic [4:0] e_count;
    logic [4:0] e_lines;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];
  int   total_checks = 0;
  int   pass_checks  = 0;

  function automatic void add(input int v, input int d, input int r, input int c,
                              input int ev, input int ed, input int ec, input int el,
                              input int eo);
    vec_t t;
    t.valid   = 1'(v);
    t.data    = 8'(d);
    t.ready   = 1'(r);
    t.clear   = 1'(c);
    t.e_valid = 1'(ev);
    t.e_data  = 8'(ed);
    t.e_count = 5'(ec);
    t.e_lines = 5'(el);
    t.e_ovf   = 1'(eo);
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total_checks++;
    if (act === exp) pass_checks++;
    else $display("FAIL %s [vec %0d]: got %0h required %0h", name, idx, act, exp);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic c);
    bus.i_valid = v;
    bus.i_data  = d;
    bus.i_ready = r;
    bus.i_clear = c;
  endtask

  logic [31:0] exp_sum;

  initial begin
    // Test 1: "hi\n" with consumer ready
    add(1,'h68,1,0, 0,0,0,0,0);
    add(1,'h69,1,0, 0,0,1,0,0);
    add(1,'h0A,1,0, 0,0,2,0,0);
    add(0,0,1,0,    1,'h68,3,1,0);
    add(0,0,1,0,    1,'h69,2,1,0);
    add(0,0,1,0,    1,'h0A,1,1,0);
    add(0,0,1,0,    0,0,0,0,0);
    // Test 2: 16 bytes without eol, then a dropped 17th byte
    for (int i = 0; i < 16; i++) add(1,'h30+i,0,0, 0,0,i,0,0);
    add(1,'h40,0,0, 1,'h30,16,0,0);
    add(0,0,0,1,    1,'h30,16,0,1);
    add(0,0,0,0,    0,0,0,0,0);
    // Test 3: full FIFO with simultaneous push and pop
    for (int i = 0; i < 16; i++) add(1,'h50+i,0,0, 0,0,i,0,0);
    add(1,'h60,1,0, 1,'h50,16,0,0);
    add(0,0,0,1,    1,'h51,16,0,0);
    add(0,0,0,0,    0,0,0,0,0);
    // Test 4: two lines held back, then drained
    add(1,'h61,0,0, 0,0,0,0,0);
    add(1,'h0A,0,0, 0,0,1,0,0);
    add(1,'h62,0,0, 1,'h61,2,1,0);
    add(1,'h0A,0,0, 1,'h61,3,1,0);
    add(0,0,1,0,    1,'h61,4,2,0);
    add(0,0,1,0,    1,'h0A,3,2,0);
    add(0,0,1,0,    0,0,2,1,0);
    add(0,0,1,0,    1,'h62,2,1,0);
    add(0,0,1,0,    1,'h0A,1,1,0);
    add(0,0,1,0,    0,0,0,0,0);
    // Test 5: clear together with a push mid-line
    add(1,'h78,0,0, 0,0,0,0,0);
    add(1,'h79,0,0, 0,0,1,0,0);
    add(1,'h7A,0,1, 0,0,2,0,0);
    add(0,0,0,0,    0,0,0,0,0);

    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_valid",    -1, 32'(bus.o_valid),    32'd0);
    check("reset_count",    -1, 32'(bus.o_count),    32'd0);
    check("reset_lines",    -1, 32'(bus.o_lines),    32'd0);
    check("reset_overflow", -1, 32'(bus.o_overflow), 32'd0);
    check("reset_sum",      -1, bus.o_sum,           32'd0);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].valid, vecs[k].data, vecs[k].ready, vecs[k].clear);
      #1;
      check("valid",    k, 32'(bus.o_valid),    32'(vecs[k].e_valid));
      check("count",    k, 32'(bus.o_count),    32'(vecs[k].e_count));
      check("lines",    k, 32'(bus.o_lines),    32'(vecs[k].e_lines));
      check("overflow", k, 32'(bus.o_overflow), 32'(vecs[k].e_ovf));
      if (vecs[k].e_valid) check("data", k, 32'(bus.o_data), 32'(vecs[k].e_data));
    end

    // Test 6: running sum of three 0xFF bytes, then asynchronous reset mid-stream
`ifdef UART_RX_BUFFER_SUM_EN
    exp_sum = 32'd765;
`else
    exp_sum = 32'd0;
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 8'hFF, 1'b0, 1'b0);
    end
    @(negedge clk);
    drive(1'b1, 8'h0A, 1'b0, 1'b0);
    #1;
    check("sum_ff_x3",   100, bus.o_sum,           exp_sum);
    check("sum_count",   100, 32'(bus.o_count),    32'd3);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    check("eol_valid",   101, 32'(bus.o_valid),    32'd1);
    check("eol_lines",   101, 32'(bus.o_lines),    32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid",    102, 32'(bus.o_valid),    32'd0);
    check("async_count",    102, 32'(bus.o_count),    32'd0);
    check("async_lines",    102, 32'(bus.o_lines),    32'd0);
    check("async_overflow", 102, 32'(bus.o_overflow), 32'd0);
    check("async_sum",      102, bus.o_sum,           32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
